// File: rtl/seq_num_gen.sv
// Numbered, parity-tagged beat source: one start launches 0, STEP, 2*STEP ... up to a captured limit.
// Optional concurrent assertions are compiled in with SEQ_NUM_GEN_SVA_EN.
module seq_num_gen #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             ready,
  output logic [WIDTH-1:0] num,
  output logic             valid,
  output logic             even,
  output logic             last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH:0]   next_sum;
  logic             final_beat;

  // One extra bit so that a sum past 2**WIDTH-1 still reads as beyond the limit.
  assign next_sum   = {1'b0, num_q} + STEP_W;
  assign final_beat = next_sum > {1'b0, lim_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      lim_q   <= lim_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    lim_d   = lim_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          lim_d   = cfg_limit;
          num_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ready) begin
          if (final_beat) begin
            num_d   = '0;
            state_d = DONE;
          end else begin
            num_d = next_sum[WIDTH-1:0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        num_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state, so a stall holds everything.
  assign valid = (state_q == RUN);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign num   = num_q;
  assign even  = valid & ~num_q[0];
  assign last  = valid & final_beat;

`ifdef SEQ_NUM_GEN_SVA_EN
  a_stall_stability: assert property (@(posedge clk) disable iff (!reset)
    valid && !ready |=> valid && $stable(num))
    else $error("stall_stability");

  a_parity: assert property (@(posedge clk) disable iff (!reset)
    valid |-> even == ~num[0])
    else $error("parity");

  a_done_pulse: assert property (@(posedge clk) disable iff (!reset)
    done |=> !done)
    else $error("done_pulse");

  a_progress: assert property (@(posedge clk) disable iff (!reset)
    valid && ready && !last |=> num == WIDTH'($past(num) + WIDTH'(STEP)))
    else $error("progress");
`endif

endmodule

// File: tb/tb_seq_num_gen.sv
// Bench for seq_num_gen: three instances (STEP 1, 2, 100) against a beat-index reference model.
module tb_seq_num_gen;

  logic       clk;
  logic       reset;
  logic       st [3];
  logic [7:0] lm [3];
  logic       rd [3];
  logic [7:0] n  [3];
  logic       v  [3];
  logic       e  [3];
  logic       l  [3];
  logic       b  [3];
  logic       d  [3];

  int checks = 0;
  int errors = 0;

  seq_num_gen #(.WIDTH(8), .STEP(1)) u0 (
    .clk(clk), .reset(reset), .start(st[0]), .cfg_limit(lm[0]), .ready(rd[0]),
    .num(n[0]), .valid(v[0]), .even(e[0]), .last(l[0]), .busy(b[0]), .done(d[0]));
  seq_num_gen #(.WIDTH(8), .STEP(2)) u1 (
    .clk(clk), .reset(reset), .start(st[1]), .cfg_limit(lm[1]), .ready(rd[1]),
    .num(n[1]), .valid(v[1]), .even(e[1]), .last(l[1]), .busy(b[1]), .done(d[1]));
  seq_num_gen #(.WIDTH(8), .STEP(100)) u2 (
    .clk(clk), .reset(reset), .start(st[2]), .cfg_limit(lm[2]), .ready(rd[2]),
    .num(n[2]), .valid(v[2]), .even(e[2]), .last(l[2]), .busy(b[2]), .done(d[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int stp(int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 100;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a stream is a beat index k over floor(lim/STEP)+1 beats; 0 idle, 1 run, 2 done.
  int ms [3] = '{0, 0, 0};
  int mk [3] = '{0, 0, 0};
  int ml [3] = '{0, 0, 0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        ms[i] = 0;
        mk[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (ms[i])
          0: if (st[i]) begin ml[i] = int'(lm[i]); mk[i] = 0; ms[i] = 1; end
          1: if (rd[i]) begin
               if (mk[i] == ml[i] / stp(i)) ms[i] = 2;
               else mk[i] = mk[i] + 1;
             end
          default: ms[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit ev;
      int en;
      ev = (ms[i] == 1);
      en = ev ? mk[i] * stp(i) : 0;
      chk($sformatf("valid[%0d]", i), 32'(v[i]), 32'(ev));
      chk($sformatf("busy[%0d]", i), 32'(b[i]), 32'(ev));
      chk($sformatf("done[%0d]", i), 32'(d[i]), 32'(ms[i] == 2));
      chk($sformatf("num[%0d]", i), 32'(n[i]), 32'(en));
      chk($sformatf("even[%0d]", i), 32'(e[i]), 32'(ev && (en % 2 == 0)));
      chk($sformatf("last[%0d]", i), 32'(l[i]), 32'(ev && (mk[i] == ml[i] / stp(i))));
    end
  end

  // Accepted beats as seen on the DUT pins, for the literal stream checks.
  int bq0[$], bq1[$], bq2[$], lq0[$];
  int dcnt0 = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (v[0] && rd[0]) begin bq0.push_back(int'(n[0])); lq0.push_back(int'(l[0])); end
      if (v[1] && rd[1]) bq1.push_back(int'(n[1]));
      if (v[2] && rd[2]) bq2.push_back(int'(n[2]));
      if (d[0]) dcnt0++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(int i, int lim);
    st[i] = 1'b1;
    lm[i] = 8'(lim);
    step();
    st[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      step();
      if (d[i]) seen = 1;
    end
    if (!seen) chk($sformatf("timeout_done[%0d]", i), 32'(seen), 32'd1);
    step();
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin st[i] = 0; lm[i] = 0; rd[i] = 0; end
    step();
    step();
    chk("rst_valid", 32'(v[0]), 32'd0);
    chk("rst_num", 32'(n[0]), 32'd0);
    chk("rst_busy", 32'(b[2]), 32'd0);
    reset = 1'b1;
    step();

    // 0..5 with STEP=1, ready held high
    rd[0] = 1; bq0.delete(); lq0.delete();
    launch(0, 5);
    wait_done(0, 20);
    chk("t1_count", 32'(bq0.size()), 32'd6);
    for (int j = 0; j < 6 && j < bq0.size(); j++) chk($sformatf("t1_beat%0d", j), 32'(bq0[j]), 32'(j));
    if (lq0.size() == 6) begin
      chk("t1_last_on_5", 32'(lq0[5]), 32'd1);
      chk("t1_no_early_last", 32'(lq0[0] + lq0[1] + lq0[2] + lq0[3] + lq0[4]), 32'd0);
    end else chk("t1_last_count", 32'(lq0.size()), 32'd6);

    // STEP=2, limit 9
    rd[1] = 1; bq1.delete();
    launch(1, 9);
    wait_done(1, 20);
    chk("t2_count", 32'(bq1.size()), 32'd5);
    for (int j = 0; j < 5 && j < bq1.size(); j++) chk($sformatf("t2_beat%0d", j), 32'(bq1[j]), 32'(2 * j));

    // stall on num=1 for three cycles
    rd[0] = 1; bq0.delete();
    launch(0, 3);
    step();
    rd[0] = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3_stall_num", 32'(n[0]), 32'd1);
      chk("t3_stall_valid", 32'(v[0]), 32'd1);
    end
    rd[0] = 1;
    wait_done(0, 20);
    chk("t3_count", 32'(bq0.size()), 32'd4);
    for (int j = 0; j < 4 && j < bq0.size(); j++) chk($sformatf("t3_beat%0d", j), 32'(bq0[j]), 32'(j));

    // STEP=100, limit 250: 300 overflows, so 200 is last
    rd[2] = 1; bq2.delete();
    launch(2, 250);
    chk("t4_model_beats", 32'(ml[2] / stp(2) + 1), 32'd3);
    wait_done(2, 20);
    chk("t4_count", 32'(bq2.size()), 32'd3);
    for (int j = 0; j < 3 && j < bq2.size(); j++) chk($sformatf("t4_beat%0d", j), 32'(bq2[j]), 32'(100 * j));

    // limit 0: one beat; restart attempts in RUN and DONE are ignored
    rd[0] = 1; bq0.delete();
    launch(0, 0);
    chk("t5_last", 32'(l[0]), 32'd1);
    chk("t5_even", 32'(e[0]), 32'd1);
    st[0] = 1; lm[0] = 8'd7;
    step();
    chk("t5_done", 32'(d[0]), 32'd1);
    step();
    st[0] = 0;
    chk("t5_no_restart", 32'(v[0]), 32'd0);
    step();
    chk("t5_idle", 32'(v[0]), 32'd0);
    chk("t5_count", 32'(bq0.size()), 32'd1);

    // reset mid-stream at num=2
    rd[0] = 1;
    launch(0, 5);
    step();
    step();
    chk("t6_num_before", 32'(n[0]), 32'd2);
    dcnt0 = 0;
    reset = 1'b0;
    #1;
    chk("t6_valid_async", 32'(v[0]), 32'd0);
    chk("t6_busy_async", 32'(b[0]), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("t6_no_done", 32'(dcnt0), 32'd0);
    bq0.delete();
    launch(0, 1);
    wait_done(0, 10);
    chk("t6_count", 32'(bq0.size()), 32'd2);
    for (int j = 0; j < 2 && j < bq0.size(); j++) chk($sformatf("t6_beat%0d", j), 32'(bq0[j]), 32'(j));

    // randomized traffic on all three instances
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        rd[i] = ($urandom_range(0, 3) != 0);
        st[i] = ($urandom_range(0, 7) == 0);
        lm[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 30));
      end
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_num_gen.md
Name: seq_num_gen

Overview:
Stimulus source that produces a numbered, parity-tagged data stream under a valid/ready handshake. It sits directly upstream of the concurrent-assertion checker bench, which samples num/even on posedge clk. A start pulse launches one stream of values 0, STEP, 2*STEP, ... up to a limit. Each beat carries an even flag and a last flag so the downstream checker can run clock-based properties against it.

Parameters:
WIDTH, 8, width of num and cfg_limit
STEP, 1, increment between successive beats (1 to 2**WIDTH-1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle launch pulse; ignored unless FSM is IDLE
cfg_limit  input  WIDTH  upper bound for the stream; captured on the accepted start
ready  input  1  downstream accepts the beat when valid && ready at posedge clk
num  output  WIDTH  current beat value
valid  output  1  beat present
even  output  1  num[0] == 0; meaningful only while valid
last  output  1  final beat of the stream; meaningful only while valid
busy  output  1  high in RUN
done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (reset low, asynchronous): FSM goes to IDLE. num=0, valid=0, even=0, last=0, busy=0, done=0, and the captured limit = 0. Release is sampled synchronously at posedge clk.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: capture lim=cfg_limit, set num=0, move to RUN. valid=1 on the next cycle, so latency start->first valid is 1 clk.
- IDLE, start=0: stay in IDLE; all outputs 0.
- RUN behaviour:
  - valid=1 and busy=1.
  - even = ~num[0].
  - last = 1 when num + STEP > lim, with the sum computed in WIDTH+1 bits so overflow counts as exceeding.
- RUN, valid && ready && !last: num <= num + STEP (WIDTH bits; no wrap is possible by the last rule). Stay in RUN.
- RUN, valid && ready && last: valid <= 0, go to DONE.
- RUN, valid && !ready (stall): num, even and last hold stable. valid must not drop. This rule is mandatory for the checker.
- DONE: done=1 for exactly one cycle, busy=0, valid=0, then go to IDLE.
- start while in RUN or DONE is ignored; no restart and no limit recapture.
- cfg_limit changes after capture have no effect on the current stream.
- cfg_limit=0 at start: a single beat num=0 with last=1.
- start in the same cycle as the DONE->IDLE transition is ignored; start is only honoured when the FSM is IDLE at the sampling edge.
- Reset asserted mid-stream: valid drops immediately (asynchronous), no done pulse. After release the block sits in IDLE.
- Beat count per stream = floor(lim/STEP)+1.

Optional Feature:
SEQ_NUM_GEN_SVA_EN:
- When defined, the module compiles in concurrent assertions, clocked on posedge clk with disable iff (!reset):
  - stall stability: valid && !ready |=> valid && $stable(num).
  - parity: valid |-> even == ~num[0].
  - done pulse: done |=> !done.
  - progress: valid && ready && !last |=> num == $past(num)+STEP.
- Each assertion has an else $error naming the property.
- When undefined, no assertion code is present and the functional behaviour is identical.

Test Plan:
- WIDTH=8, STEP=1, cfg_limit=5, start, ready=1 -> beats 0,1,2,3,4,5 on consecutive cycles; even=1,0,1,0,1,0; last only on 5; done pulses 1 cycle after beat 5.
- STEP=2, cfg_limit=9, ready=1 -> beats 0,2,4,6,8; even=1 on all beats; last on 8; 5 beats total.
- STEP=1, cfg_limit=3, ready low for 3 cycles while num=1 -> num holds 1 and valid stays 1 for 3 cycles; the stream then resumes 2,3.
- STEP=100, cfg_limit=250 (WIDTH=8) -> beats 0,100,200, with last on 200 because 300 overflows/exceeds the limit; no wrap to 44.
- cfg_limit=0 -> single beat num=0, last=1, even=1; done next cycle. A second start issued during RUN has no effect.
- Reset low while num=2 of a 0..5 stream -> valid/busy go to 0 immediately and no done pulse. After release, start with cfg_limit=1 -> beats 0,1.
